// File: rtl/incache_pkg.sv
// Shared types and constants for the instruction-cache RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package incache_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  // Which requester owns an access travelling down the read-return pipe.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LDR   = 1'b1
  } owner_e;

  // Tag pushed per granted access; valid is set only for reads.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_FETCH};

endpackage

// File: rtl/incache_rd_pipe.sv
// Delays the read tag of each granted access to line up with RAM douta.
// Latency: RD_LATENCY cycles from push to head.
// Backpressure: none; one tag enters and one leaves every cycle.
module incache_rd_pipe
  import incache_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clka,
  input  logic    rst_n,
  input  rd_tag_t push_tag,
  output rd_tag_t head_tag
);

  rd_tag_t tag_q [RD_LATENCY];
  rd_tag_t tag_d [RD_LATENCY];

  // Shift every stage one step toward the head; new tag enters stage 0.
  always_comb begin
    tag_d[0] = push_tag;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Stage registers; reset drops anything in flight so no stale rvalid appears.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= TAG_IDLE;
      end
    end else begin
      tag_q <= tag_d;
    end
  end

  assign head_tag = tag_q[RD_LATENCY-1];

endmodule

// File: rtl/incache_arbiter.sv
// Arbitrates fetch (read-only) and loader (read/write) onto the single-port InCache RAM.
// Latency: grant is combinational; read data returns RD_LATENCY cycles after the grant.
// Backpressure: requesters hold req until gnt; one access is granted per cycle.
module incache_arbiter #(
  parameter int ADDR_W     = incache_pkg::ADDR_W,
  parameter int DATA_W     = incache_pkg::DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int LDR_PRIO   = 0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  import incache_pkg::*;

  owner_e            rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              f_win, l_win;
  rd_tag_t           push_tag, head_tag;

  // Pick the winner from live requests and the rr pointer; nothing is granted in reset.
  always_comb begin
    f_win = 1'b0;
    l_win = 1'b0;
    if (rst_n) begin
      if (l_req && (!f_req || (LDR_PRIO != 0) || (rr_q == OWN_LDR))) begin
        l_win = 1'b1;
      end else if (f_req) begin
        f_win = 1'b1;
      end
    end
  end

  assign f_gnt = f_win;
  assign l_gnt = l_win;

  // Steer the winner onto the RAM, hand preference to the loser, and tag the access.
  always_comb begin
    rr_d     = rr_q;
    addr_d   = addr_q;
    ram_wea  = 1'b0;
    ram_dina = l_wdata;
    push_tag = TAG_IDLE;
    if (l_win) begin
      rr_d     = OWN_FETCH;
      addr_d   = l_addr;
      ram_wea  = l_we;
      push_tag = '{valid: !l_we, owner: OWN_LDR};
    end else if (f_win) begin
      rr_d     = OWN_LDR;
      addr_d   = f_addr;
      push_tag = '{valid: 1'b1, owner: OWN_FETCH};
    end
  end

  // In idle cycles the RAM keeps seeing the last granted address.
  assign ram_addra = addr_d;

  // rr pointer and held address.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= OWN_FETCH;
      addr_q <= '0;
    end else begin
      rr_q   <= rr_d;
      addr_q <= addr_d;
    end
  end

  incache_rd_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clka    (clka),
    .rst_n   (rst_n),
    .push_tag(push_tag),
    .head_tag(head_tag)
  );

  assign f_rvalid = head_tag.valid && (head_tag.owner == OWN_FETCH);
  assign l_rvalid = head_tag.valid && (head_tag.owner == OWN_LDR);
  assign f_rdata  = ram_douta;
  assign l_rdata  = ram_douta;

endmodule

// File: tb/tb_incache_arbiter.sv
// Self-checking bench: three arbiter builds (rr/lat1, ldr-prio/lat1, rr/lat2) with RAM models.
// Latency: checks grants every cycle and returns at grant+RD_LATENCY against a queue model.
// Backpressure: requester tasks hold req until gnt, bounded by a cycle budget.
module tb_incache_arbiter;

  logic clka = 1'b0;
  logic rst_n = 1'b0;
  always #5 clka = ~clka;

  logic        f_req    [3];
  logic [12:0] f_addr   [3];
  logic        f_gnt    [3];
  logic        f_rvalid [3];
  logic [31:0] f_rdata  [3];
  logic        l_req    [3];
  logic        l_we     [3];
  logic [12:0] l_addr   [3];
  logic [31:0] l_wdata  [3];
  logic        l_gnt    [3];
  logic        l_rvalid [3];
  logic [31:0] l_rdata  [3];
  logic        ram_wea  [3];
  logic [12:0] ram_addra[3];
  logic [31:0] ram_dina [3];
  logic [31:0] ram_douta[3];

  incache_arbiter #(.RD_LATENCY(1), .LDR_PRIO(0)) u0 (
    .clka(clka), .rst_n(rst_n),
    .f_req(f_req[0]), .f_addr(f_addr[0]), .f_gnt(f_gnt[0]), .f_rvalid(f_rvalid[0]), .f_rdata(f_rdata[0]),
    .l_req(l_req[0]), .l_we(l_we[0]), .l_addr(l_addr[0]), .l_wdata(l_wdata[0]), .l_gnt(l_gnt[0]),
    .l_rvalid(l_rvalid[0]), .l_rdata(l_rdata[0]),
    .ram_wea(ram_wea[0]), .ram_addra(ram_addra[0]), .ram_dina(ram_dina[0]), .ram_douta(ram_douta[0]));

  incache_arbiter #(.RD_LATENCY(1), .LDR_PRIO(1)) u1 (
    .clka(clka), .rst_n(rst_n),
    .f_req(f_req[1]), .f_addr(f_addr[1]), .f_gnt(f_gnt[1]), .f_rvalid(f_rvalid[1]), .f_rdata(f_rdata[1]),
    .l_req(l_req[1]), .l_we(l_we[1]), .l_addr(l_addr[1]), .l_wdata(l_wdata[1]), .l_gnt(l_gnt[1]),
    .l_rvalid(l_rvalid[1]), .l_rdata(l_rdata[1]),
    .ram_wea(ram_wea[1]), .ram_addra(ram_addra[1]), .ram_dina(ram_dina[1]), .ram_douta(ram_douta[1]));

  incache_arbiter #(.RD_LATENCY(2), .LDR_PRIO(0)) u2 (
    .clka(clka), .rst_n(rst_n),
    .f_req(f_req[2]), .f_addr(f_addr[2]), .f_gnt(f_gnt[2]), .f_rvalid(f_rvalid[2]), .f_rdata(f_rdata[2]),
    .l_req(l_req[2]), .l_we(l_we[2]), .l_addr(l_addr[2]), .l_wdata(l_wdata[2]), .l_gnt(l_gnt[2]),
    .l_rvalid(l_rvalid[2]), .l_rdata(l_rdata[2]),
    .ram_wea(ram_wea[2]), .ram_addra(ram_addra[2]), .ram_dina(ram_dina[2]), .ram_douta(ram_douta[2]));

  function automatic bit prio_of(input int k);
    return k == 1;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // RAM models: synchronous read, optional output register on instance 2.
  logic [31:0] rmem [3][8192];
  logic [31:0] rq1 [3];
  logic [31:0] rq2 [3];
  always @(posedge clka) begin
    for (int k = 0; k < 3; k++) begin
      rq1[k] <= rmem[k][ram_addra[k]];
      rq2[k] <= rq1[k];
      if (ram_wea[k]) rmem[k][ram_addra[k]] <= ram_dina[k];
    end
  end
  assign ram_douta[0] = rq1[0];
  assign ram_douta[1] = rq1[1];
  assign ram_douta[2] = rq2[2];

  // Behavioural model state.
  typedef struct {
    int          due;
    bit          own;
    logic [31:0] d;
  } exp_t;
  typedef struct {
    int          c;
    logic [31:0] d;
  } ret_t;

  logic [31:0] mmem [3][8192];
  exp_t        pq   [3][$];
  ret_t        fret [3][$];
  ret_t        lret [3][$];
  bit          pref_l   [3];
  bit          have_last[3];
  logic [12:0] last_addr[3];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  // Compare DUT outputs with the model every cycle, then advance the model.
  always @(negedge clka) begin
    bit          fw, lw, efv, elv;
    logic [31:0] ed;
    exp_t        e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk(k, "rst_f_gnt", 32'(f_gnt[k]), 0);
        chk(k, "rst_l_gnt", 32'(l_gnt[k]), 0);
        chk(k, "rst_f_rvalid", 32'(f_rvalid[k]), 0);
        chk(k, "rst_l_rvalid", 32'(l_rvalid[k]), 0);
        chk(k, "rst_wea", 32'(ram_wea[k]), 0);
        pq[k].delete();
        pref_l[k] = 1'b0;
        have_last[k] = 1'b0;
      end else begin
        fw = 1'b0;
        lw = 1'b0;
        if (f_req[k] && l_req[k]) begin
          if (prio_of(k) || pref_l[k]) lw = 1'b1;
          else fw = 1'b1;
        end else if (l_req[k]) begin
          lw = 1'b1;
        end else if (f_req[k]) begin
          fw = 1'b1;
        end
        chk(k, "f_gnt", 32'(f_gnt[k]), 32'(fw));
        chk(k, "l_gnt", 32'(l_gnt[k]), 32'(lw));
        chk(k, "wea", 32'(ram_wea[k]), 32'(lw && l_we[k]));
        if (fw) chk(k, "addra_f", 32'(ram_addra[k]), 32'(f_addr[k]));
        else if (lw) begin
          chk(k, "addra_l", 32'(ram_addra[k]), 32'(l_addr[k]));
          chk(k, "dina", ram_dina[k], l_wdata[k]);
        end else if (have_last[k]) chk(k, "addra_hold", 32'(ram_addra[k]), 32'(last_addr[k]));

        efv = 1'b0;
        elv = 1'b0;
        ed = '0;
        if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
          e = pq[k].pop_front();
          if (e.own) elv = 1'b1;
          else efv = 1'b1;
          ed = e.d;
        end
        chk(k, "f_rvalid", 32'(f_rvalid[k]), 32'(efv));
        chk(k, "l_rvalid", 32'(l_rvalid[k]), 32'(elv));
        if (efv) chk(k, "f_rdata", f_rdata[k], ed);
        if (elv) chk(k, "l_rdata", l_rdata[k], ed);
        if (f_rvalid[k]) fret[k].push_back('{c: cyc, d: f_rdata[k]});
        if (l_rvalid[k]) lret[k].push_back('{c: cyc, d: l_rdata[k]});

        if (fw || lw) begin
          pref_l[k] = fw;
          have_last[k] = 1'b1;
          last_addr[k] = fw ? f_addr[k] : l_addr[k];
          if (lw && l_we[k]) mmem[k][l_addr[k]] = l_wdata[k];
          else pq[k].push_back('{due: cyc + lat_of(k), own: lw, d: mmem[k][last_addr[k]]});
        end
      end
    end
  end

  // Requester tasks: called at posedge+1, hold req until gnt, return grant cycle.
  task automatic f_issue(input int k, input logic [12:0] a, output int gc);
    bit got;
    got = 1'b0;
    gc = -1;
    f_req[k] = 1'b1;
    f_addr[k] = a;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clka);
      if (f_gnt[k]) begin
        got = 1'b1;
        gc = cyc;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL f_gnt_timeout inst=%0d addr=%h got=none want=gnt", k, a);
    end
    @(posedge clka);
    #1;
    f_req[k] = 1'b0;
  endtask

  task automatic l_issue(input int k, input logic we, input logic [12:0] a, input logic [31:0] wd,
                         output int gc);
    bit got;
    got = 1'b0;
    gc = -1;
    l_req[k] = 1'b1;
    l_we[k] = we;
    l_addr[k] = a;
    l_wdata[k] = wd;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clka);
      if (l_gnt[k]) begin
        got = 1'b1;
        gc = cyc;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL l_gnt_timeout inst=%0d addr=%h got=none want=gnt", k, a);
    end
    @(posedge clka);
    #1;
    l_req[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic rand_f(input int k, input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      f_issue(k, 13'($urandom_range(0, 15)), g);
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic rand_l(input int k, input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      l_issue(k, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)), $urandom, g);
      idle($urandom_range(prio_of(k) ? 1 : 0, 2));
    end
  endtask

  int fg [8];
  int lg [4];
  int g0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      f_req[k] = 1'b0;
      f_addr[k] = '0;
      l_req[k] = 1'b0;
      l_we[k] = 1'b0;
      l_addr[k] = '0;
      l_wdata[k] = '0;
      for (int a = 0; a < 8192; a++) begin
        rmem[k][a] = init_val(a);
        mmem[k][a] = init_val(a);
      end
    end
    repeat (3) @(posedge clka);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Reset with a read in flight on every build: the read must never return.
    fork
      f_issue(0, 13'h0003, fg[0]);
      f_issue(1, 13'h0003, fg[1]);
      f_issue(2, 13'h0003, fg[2]);
    join
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    for (int k = 0; k < 3; k++) chk(k, "no_ret_after_reset", 32'(fret[k].size()), 0);

    // Loader write then read of the same word.
    l_issue(0, 1'b1, 13'h0010, 32'hDEADBEEF, g0);
    l_issue(0, 1'b0, 13'h0010, 32'h0, g0);
    idle(3);
    chk(0, "wr_rd_count", 32'(lret[0].size()), 1);
    if (lret[0].size() == 1) begin
      chk(0, "wr_rd_cycle", 32'(lret[0][0].c), 32'(g0 + 1));
      chk(0, "wr_rd_data", lret[0][0].d, 32'hDEADBEEF);
    end
    chk(0, "wr_rd_no_f", 32'(fret[0].size()), 0);

    // Round-robin contention: grants alternate F,L,F,L,F,L.
    l_issue(0, 1'b1, 13'h0001, 32'h11111111, g0);
    l_issue(0, 1'b1, 13'h0002, 32'h22222222, g0);
    lret[0].delete();
    fork
      begin
        for (int i = 0; i < 3; i++) f_issue(0, 13'h0001, fg[i]);
      end
      begin
        for (int i = 0; i < 3; i++) l_issue(0, 1'b0, 13'h0002, 32'h0, lg[i]);
      end
    join
    idle(2);
    for (int i = 0; i < 3; i++) begin
      chk(0, "rr_f_gnt_cyc", 32'(fg[i]), 32'(fg[0] + 2 * i));
      chk(0, "rr_l_gnt_cyc", 32'(lg[i]), 32'(fg[0] + 2 * i + 1));
    end
    chk(0, "rr_f_ret_n", 32'(fret[0].size()), 3);
    chk(0, "rr_l_ret_n", 32'(lret[0].size()), 3);
    for (int i = 0; i < 3 && i < fret[0].size() && i < lret[0].size(); i++) begin
      chk(0, "rr_f_ret", fret[0][i].d, 32'h11111111);
      chk(0, "rr_l_ret", lret[0][i].d, 32'h22222222);
      chk(0, "rr_f_ret_cyc", 32'(fret[0][i].c), 32'(fg[0] + 2 * i + 1));
    end

    // Fetch never writes, even with l_we held high and no loader request.
    fret[0].delete();
    l_we[0] = 1'b1;
    l_wdata[0] = 32'hCAFEF00D;
    f_issue(0, 13'h1FFF, g0);
    idle(2);
    l_we[0] = 1'b0;
    chk(0, "top_addr_unchanged", rmem[0][8191], init_val(8191));
    if (fret[0].size() == 1) chk(0, "top_addr_read", fret[0][0].d, init_val(8191));
    else chk(0, "top_addr_read_n", 32'(fret[0].size()), 1);

    // Loader priority: fetch waits out 4 loader reads, then wins right away.
    fork
      begin
        for (int i = 0; i < 4; i++) l_issue(1, 1'b0, 13'(i + 4), 32'h0, lg[i]);
      end
      f_issue(1, 13'h0020, g0);
    join
    for (int i = 1; i < 4; i++) chk(1, "prio_l_gnt_cyc", 32'(lg[i]), 32'(lg[0] + i));
    chk(1, "prio_f_gnt_cyc", 32'(g0), 32'(lg[0] + 4));

    // Two-cycle read latency: back-to-back fetch stream returns in order.
    fret[2].delete();
    for (int i = 0; i < 8; i++) f_issue(2, 13'(i), fg[i]);
    idle(4);
    chk(2, "lat2_ret_n", 32'(fret[2].size()), 8);
    for (int i = 0; i < 8 && i < fret[2].size(); i++) begin
      chk(2, "lat2_gnt_cyc", 32'(fg[i]), 32'(fg[0] + i));
      chk(2, "lat2_ret_cyc", 32'(fret[2][i].c), 32'(fg[0] + 2 + i));
      chk(2, "lat2_ret_data", fret[2][i].d, init_val(i));
    end

    // Random traffic on all builds, both requesters concurrently.
    fork
      rand_f(0, 150);
      rand_l(0, 150);
      rand_f(1, 150);
      rand_l(1, 150);
      rand_f(2, 150);
      rand_l(2, 150);
    join
    idle(4);
    for (int k = 0; k < 3; k++) chk(k, "pending_drained", 32'(pq[k].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/incache_arbiter.md
Name: incache_arbiter

Overview:
- Shares the single-port instruction cache RAM (InCache, 8K x 32, one-cycle synchronous read) between two requesters.
- Requester 0 is the processor fetch unit, which only reads. Requester 1 is the program loader/debug port, which reads and writes.
- The block drives the RAM's wea/addra/dina, returns douta tagged with the owning requester, and uses round-robin or fixed-priority arbitration with a req/gnt handshake.

Parameters:
- ADDR_W, 13, RAM word address width.
- DATA_W, 32, RAM data width.
- RD_LATENCY, 1, RAM read latency in cycles. Legal values are 1 and 2 (2 = BRAM output register enabled).
- LDR_PRIO, 0, arbitration mode. 0 = round-robin. 1 = loader always wins.

Ports:
- clka  in  1  clock, shared with the RAM
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request; held until f_gnt
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  DATA_W  fetch read data
- l_req  in  1  loader request; held until l_gnt
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  ADDR_W  loader word address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  l_rdata valid (reads only)
- l_rdata  out  DATA_W  loader read data
- ram_wea  out  1  to InCache wea
- ram_addra  out  ADDR_W  to InCache addra
- ram_dina  out  DATA_W  to InCache dina
- ram_douta  in  DATA_W  from InCache douta

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Pipeline valid bits clear and the rr pointer goes to 0 (fetch preferred).
  - f_rvalid=0, l_rvalid=0, ram_wea=0.
  - Gnts are 0 while rst_n=0.
  - An access in flight when reset asserts is dropped: no rvalid is ever produced for it.
- Arbitration is combinational from req and the registered rr pointer. At most one gnt is high per cycle.
- Round-robin (LDR_PRIO=0):
  - Single req: that requester wins.
  - Both req: the winner is the requester selected by rr.
  - After any grant, rr points to the other requester. This guarantees alternation under continuous contention.
- LDR_PRIO=1: l_req always wins. Fetch is granted only when l_req=0; starvation of fetch is acceptable in this mode.
- RAM drive, in the grant cycle N:
  - ram_addra = winner address.
  - ram_wea = l_we when the loader wins, else 0. The fetch path can never write.
  - ram_dina = l_wdata.
  - In idle cycles (no gnt): ram_wea=0, ram_addra holds the last granted address, ram_dina don't-care.
- Requesters may change addr/data or drop req only after seeing gnt.
- Return pipeline:
  - Each granted read pushes {valid=1, owner} into an RD_LATENCY-deep shift register. Writes push valid=0.
  - In cycle N+RD_LATENCY, the owner's rvalid=1 for exactly one cycle and its rdata = ram_douta.
  - The non-owner's rvalid=0. Both rdata outputs are combinational pass-throughs of ram_douta and are valid only with rvalid.
- Throughput: one access per cycle. Back-to-back grants are allowed with no bubbles. Interleaved reads of both requesters return in grant order.
- A write immediately followed by a read to the same address returns the new data. This holds because the RAM is single-port and the accesses are sequential.
- Simultaneous l_req with l_we=1 and f_req under round-robin: arbitration is the same as for reads, and only the winner is acknowledged.

Decomposition:
- Package incache_pkg:
  - constants ADDR_W=13 and DATA_W=32;
  - owner enum OWN_FETCH=0, OWN_LDR=1;
  - struct rd_tag_t {valid, owner}.
- Sub-module incache_rd_pipe: the RD_LATENCY-deep rd_tag_t shift register with async reset. It outputs the tag at the pipe head.
- The arbiter top holds the gnt logic, the rr register and the RAM muxing.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with a read in flight -> no rvalid after release; ram_wea=0 throughout.
- Loader write then read: l_req, l_we=1, addr 0x0010, wdata 0xDEADBEEF; then an l read of 0x0010 -> l_rvalid exactly RD_LATENCY cycles after the read's l_gnt, l_rdata=0xDEADBEEF, f_rvalid=0.
- Contention, round-robin: f_req and l_req both held for 6 cycles, reading 0x0001 and 0x0002 (preloaded with 0x11111111 / 0x22222222) -> gnts alternate F,L,F,L,F,L; rvalids alternate with the correct data.
- LDR_PRIO=1: both requesting for 4 loader reads -> f_gnt=0 for 4 cycles; f_gnt=1 in the first cycle l_req drops.
- Fetch never writes: f_req with addr 0x1FFF (top wrap address) while l_we=1 is held but l_req=0 -> ram_wea=0; data at 0x1FFF unchanged.
- RD_LATENCY=2 build: a back-to-back fetch stream over 0x0000-0x0007 -> 8 consecutive f_rvalid pulses starting 2 cycles after the first gnt, in address order.
